// File: rtl/sseg2bcd_pkg.sv
// -----------------------------------------------------------------------------
// sseg2bcd_pkg
// Shared definitions for the seven-segment to binary reconstructor:
//   - FSM state encoding (IDLE / CAPTURE / ASSEMBLE)
//   - active-low segment patterns (abcdefg, 'a' is the MSB of a [6:0] vector)
//   - anode position indices and the active-low anode codes that select them
//   - small helpers that classify an anode vector
// No ports; imported by sseg_digit_dec and sseg2bcd.
// -----------------------------------------------------------------------------
package sseg2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_ASSEMBLE = 2'd2
  } state_t;

  // Segment patterns, active-low, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit positions; the index is also the bit in the capture mask
  localparam logic [1:0] POS_N2_UNITS = 2'd0;
  localparam logic [1:0] POS_N2_TENS  = 2'd1;
  localparam logic [1:0] POS_N1_UNITS = 2'd2;
  localparam logic [1:0] POS_N1_TENS  = 2'd3;

  // Active-low anode codes selecting exactly one position
  localparam logic [3:0] AN_N2_UNITS = 4'b1110;
  localparam logic [3:0] AN_N2_TENS  = 4'b1101;
  localparam logic [3:0] AN_N1_UNITS = 4'b1011;
  localparam logic [3:0] AN_N1_TENS  = 4'b0111;
  localparam logic [3:0] AN_BLANK    = 4'b1111;

  // True when exactly one anode is driven
  function automatic logic an_one_low(input logic [3:0] an);
    logic one_low;
    case (an)
      AN_N2_UNITS, AN_N2_TENS, AN_N1_UNITS, AN_N1_TENS: one_low = 1'b1;
      default:                                          one_low = 1'b0;
    endcase
    return one_low;
  endfunction

  // Position index of a single-low anode code (0 for anything else)
  function automatic logic [1:0] an_pos(input logic [3:0] an);
    logic [1:0] pos;
    case (an)
      AN_N2_UNITS: pos = POS_N2_UNITS;
      AN_N2_TENS:  pos = POS_N2_TENS;
      AN_N1_UNITS: pos = POS_N1_UNITS;
      AN_N1_TENS:  pos = POS_N1_TENS;
      default:     pos = 2'd0;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/sseg_digit_dec.sv
// -----------------------------------------------------------------------------
// sseg_digit_dec
// Combinational decode of one active-low seven-segment pattern to a BCD digit.
// Ports:
//   i_seg  [6:0] in  segment pattern, bit 6 = a ... bit 0 = g, active-low
//   i_tens       in  pattern belongs to a tens position (blank allowed as 0)
//   digit  [3:0] out decoded digit (0 when bad)
//   bad          out pattern is not a legal digit for this position
// -----------------------------------------------------------------------------
module sseg_digit_dec
  import sseg2bcd_pkg::*;
(
  input  logic [6:0] i_seg,
  input  logic       i_tens,
  output logic [3:0] digit,
  output logic       bad
);

  // Table lookup; an all-off tens digit is a suppressed leading zero
  always_comb begin
    digit = 4'd0;
    bad   = 1'b0;
    case (i_seg)
      SEG_0: digit = 4'd0;
      SEG_1: digit = 4'd1;
      SEG_2: digit = 4'd2;
      SEG_3: digit = 4'd3;
      SEG_4: digit = 4'd4;
      SEG_5: digit = 4'd5;
      SEG_6: digit = 4'd6;
      SEG_7: digit = 4'd7;
      SEG_8: digit = 4'd8;
      SEG_9: digit = 4'd9;
      SEG_BLANK: begin
        digit = 4'd0;
        if (i_tens) begin
          bad = 1'b0;
        end else begin
          bad = 1'b1;
        end
      end
      default: begin
        digit = 4'd0;
        bad   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sseg2bcd.sv
// -----------------------------------------------------------------------------
// sseg2bcd
// Watches a multiplexed 4-digit active-low seven-segment display and rebuilds
// the two 2-digit numbers shown on it (num1 on an[3:2], num2 on an[1:0]).
// Each anode dwell is debounced by a stability counter and sampled once; after
// all four positions have been captured the frame is assembled into binary.
// Parameters:
//   STABLE_CYCLES  identical {an,sseg} samples needed before acceptance (2..255)
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-low
//   sseg  [0:6]    segment lines, active-low, sseg[0] = a
//   an    [3:0]    anode enables, active-low
//   num1  [3:0]    last good value of the first number
//   num2  [3:0]    last good value of the second number
//   valid          one-cycle pulse when num1/num2 are loaded
//   err            decode-fault level, cleared by the next good frame
//   err_cnt [7:0]  saturating fault counter (only with SSEG2BCD_ERRCNT_EN)
// Optional feature macro: SSEG2BCD_ERRCNT_EN
// -----------------------------------------------------------------------------
module sseg2bcd
  import sseg2bcd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:6] sseg,
  input  logic [3:0] an,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic       valid,
  output logic       err
`ifdef SSEG2BCD_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] STAB_HIT = 8'(STABLE_CYCLES - 1);

  // Reorders the ascending port range so 'a' lands in bit 6
  logic [6:0]       w_seg;

  logic [3:0]       r_in_an;
  logic [6:0]       r_in_seg;
  logic [3:0]       r_prev_an;
  logic [6:0]       r_prev_seg;
  logic [7:0]       r_cnt;

  logic             w_same;
  logic             w_hit;
  logic             w_one_low;
  logic             w_blank_an;
  logic             w_sample;
  logic             w_reject;
  logic [1:0]       w_pos_idx;
  logic [3:0]       w_pos_bit;
  logic             w_tens;
  logic [3:0]       w_digit;
  logic             w_bad;

  state_t           r_state;
  logic [3:0]       r_mask;
  logic             r_faulty;
  logic [3:0][3:0]  r_dig;
  logic [3:0]       r_num1;
  logic [3:0]       r_num2;
  logic             r_valid;
  logic             r_err;

  logic [6:0]       w_val1;
  logic [6:0]       w_val2;
  logic             w_ovf;

  assign w_seg = sseg;

  // Input register: everything downstream works on this copy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_an    <= 4'b1111;
      r_in_seg   <= 7'b1111111;
      r_prev_an  <= 4'b1111;
      r_prev_seg <= 7'b1111111;
    end else begin
      r_in_an    <= an;
      r_in_seg   <= w_seg;
      r_prev_an  <= r_in_an;
      r_prev_seg <= r_in_seg;
    end
  end

  assign w_same = ({r_in_an, r_in_seg} == {r_prev_an, r_prev_seg});

  // Stability counter: counts repeats of the registered input, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 8'd0;
    end else if (!w_same) begin
      r_cnt <= 8'd0;
    end else if (r_cnt < STAB_MAX) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // w_same is also required so that a count left at STAB_HIT by a
  // just-ended dwell cannot sample the first cycle of the next one.
  assign w_hit      = w_same && (r_cnt == STAB_HIT);
  assign w_one_low  = an_one_low(r_in_an);
  assign w_blank_an = (r_in_an == AN_BLANK);
  assign w_sample   = w_hit && w_one_low;
  assign w_reject   = w_hit && !w_one_low && !w_blank_an;
  assign w_pos_idx  = an_pos(r_in_an);
  assign w_pos_bit  = 4'b0001 << w_pos_idx;
  assign w_tens     = (w_pos_idx == POS_N1_TENS) || (w_pos_idx == POS_N2_TENS);

  sseg_digit_dec u_dec (
    .i_seg  (r_in_seg),
    .i_tens (w_tens),
    .digit  (w_digit),
    .bad    (w_bad)
  );

  // Digit store: a sampled digit always lands in its position, in any state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dig <= '0;
    end else if (w_sample) begin
      r_dig[w_pos_idx] <= w_digit;
    end else begin
      r_dig <= r_dig;
    end
  end

  // Values are formed 7 bits wide so that 20..99 cannot alias back below 16
  assign w_val1 = ({3'b000, r_dig[POS_N1_TENS]} * 7'd10) + {3'b000, r_dig[POS_N1_UNITS]};
  assign w_val2 = ({3'b000, r_dig[POS_N2_TENS]} * 7'd10) + {3'b000, r_dig[POS_N2_UNITS]};
  assign w_ovf  = (w_val1 > 7'd15) || (w_val2 > 7'd15);

  // Frame FSM with registered num/valid/err outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_mask   <= 4'b0000;
      r_faulty <= 1'b0;
      r_num1   <= 4'd0;
      r_num2   <= 4'd0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sample) begin
            r_mask   <= r_mask | w_pos_bit;
            r_faulty <= r_faulty | w_bad;
            r_state  <= ST_CAPTURE;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          if (w_sample) begin
            r_mask   <= r_mask | w_pos_bit;
            r_faulty <= r_faulty | w_bad;
            // Leave on the completing sample so ASSEMBLE is the next cycle
            if ((r_mask | w_pos_bit) == 4'b1111) begin
              r_state <= ST_ASSEMBLE;
            end else begin
              r_state <= ST_CAPTURE;
            end
          end else begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_ASSEMBLE: begin
          if (r_faulty || w_ovf) begin
            r_err <= 1'b1;
          end else begin
            r_num1  <= w_val1[3:0];
            r_num2  <= w_val2[3:0];
            r_valid <= 1'b1;
            r_err   <= 1'b0;
          end
          // A digit sampled now opens the next frame
          if (w_sample) begin
            r_mask   <= w_pos_bit;
            r_faulty <= w_bad;
          end else begin
            r_mask   <= 4'b0000;
            r_faulty <= 1'b0;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mask   <= 4'b0000;
          r_faulty <= 1'b0;
        end
      endcase
      // Faults seen this cycle win over a clear from ASSEMBLE
      if (w_reject || (w_sample && w_bad)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign num1  = r_num1;
  assign num2  = r_num2;
  assign valid = r_valid;
  assign err   = r_err;

`ifdef SSEG2BCD_ERRCNT_EN
  logic       w_frame_bad;
  logic [1:0] w_inc;
  logic [8:0] w_cnt_sum;
  logic [7:0] r_err_cnt;

  assign w_frame_bad = (r_state == ST_ASSEMBLE) && (r_faulty || w_ovf);
  assign w_inc       = {1'b0, w_frame_bad} + {1'b0, w_reject};
  assign w_cnt_sum   = {1'b0, r_err_cnt} + {7'b0000000, w_inc};

  // Saturating count of rejected frames and rejected anode dwells
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= 8'd0;
    end else if (w_cnt_sum > 9'd255) begin
      r_err_cnt <= 8'd255;
    end else begin
      r_err_cnt <= w_cnt_sum[7:0];
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_sseg2bcd.sv
// -----------------------------------------------------------------------------
// tb_sseg2bcd
// Directed stimulus of display dwells; expected frames are queued when the
// last digit of a frame is driven and popped when valid pulses.
// -----------------------------------------------------------------------------
module tb_sseg2bcd;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;

  logic       clk;
  logic       rst;
  logic [0:6] sseg;
  logic [3:0] an;
  logic [3:0] num1;
  logic [3:0] num2;
  logic       valid;
  logic       err;
`ifdef SSEG2BCD_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  typedef struct {
    logic [3:0] n1;
    logic [3:0] n2;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_cmp;
  int   n_fail;
  int   exp_cnt;

  sseg2bcd #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .sseg  (sseg),
    .an    (an),
    .num1  (num1),
    .num2  (num2),
    .valid (valid),
    .err   (err)
`ifdef SSEG2BCD_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest queued frame
  always @(negedge clk) begin
    if (rst === 1'b1 && valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", {31'd0, valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("num1", {28'd0, num1}, {28'd0, e.n1});
        chk("num2", {28'd0, num2}, {28'd0, e.n2});
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  // One 8-cycle anode dwell; optional 2-cycle all-segments-on glitch
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input bit glitch,
                       input bit push, input logic [3:0] e1, input logic [3:0] e2);
    exp_t e;
    an   = a;
    sseg = s;
    if (push) begin
      e.n1 = e1;
      e.n2 = e2;
      e.cyc = cyc + 7;  // register, 4 stable cycles, capture, assemble
      exp_q.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      if (glitch && i == 5) sseg = 7'b0000000;
      if (glitch && i == 7) sseg = s;
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input logic [6:0] t1, input logic [6:0] u1, input logic [6:0] t2,
                       input logic [6:0] u2, input bit glitch, input bit push,
                       input logic [3:0] e1, input logic [3:0] e2);
    dwell(4'b0111, t1, 1'b0, 1'b0, 4'd0, 4'd0);
    dwell(4'b1011, u1, glitch, 1'b0, 4'd0, 4'd0);
    dwell(4'b1101, t2, 1'b0, 1'b0, 4'd0, 4'd0);
    dwell(4'b1110, u2, 1'b0, push, e1, e2);
  endtask

  initial begin
    cyc     = 0;
    n_cmp   = 0;
    n_fail  = 0;
    exp_cnt = 0;
    rst     = 1'b0;
    an      = 4'b1111;
    sseg    = SB;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_num1", {28'd0, num1}, 32'd0);
    chk("rst_num2", {28'd0, num2}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
`ifdef SSEG2BCD_ERRCNT_EN
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    rst = 1'b1;

    // 5 and 15, three frames
    for (int f = 0; f < 3; f++) frame(SB, S5, S1, S5, 1'b0, 1'b1, 4'd5, 4'd15);
    chk("err_good", {31'd0, err}, 32'd0);

    // Glitch inside the num1-units dwell must not be captured
    frame(SB, S5, S1, S5, 1'b1, 1'b1, 4'd5, 4'd15);
    chk("err_glitch", {31'd0, err}, 32'd0);

    // 25 on num1: overflow, values hold
    frame(S2, S5, S1, S5, 1'b0, 1'b0, 4'd0, 4'd0);
    exp_cnt = exp_cnt + 1;
    chk("err_ovf", {31'd0, err}, 32'd1);
    chk("ovf_num1_hold", {28'd0, num1}, 32'd5);
    chk("ovf_num2_hold", {28'd0, num2}, 32'd15);
`ifdef SSEG2BCD_ERRCNT_EN
    chk("err_cnt_ovf", {24'd0, err_cnt}, exp_cnt);
`endif
    frame(SB, S5, S1, S5, 1'b0, 1'b1, 4'd5, 4'd15);
    chk("err_cleared", {31'd0, err}, 32'd0);

    // Blanking dwell with arbitrary segments: ignored
    dwell(4'b1111, 7'b0101010, 1'b0, 1'b0, 4'd0, 4'd0);
    chk("err_blank_an", {31'd0, err}, 32'd0);

    // Two anodes low: rejected dwell
    dwell(4'b1100, S5, 1'b0, 1'b0, 4'd0, 4'd0);
    exp_cnt = exp_cnt + 1;
    chk("err_multi_an", {31'd0, err}, 32'd1);
`ifdef SSEG2BCD_ERRCNT_EN
    chk("err_cnt_multi_an", {24'd0, err_cnt}, exp_cnt);
`endif
    frame(SB, S5, S1, S5, 1'b0, 1'b1, 4'd5, 4'd15);
    chk("err_cleared2", {31'd0, err}, 32'd0);

    // Reset after two digits of a frame
    dwell(4'b0111, SB, 1'b0, 1'b0, 4'd0, 4'd0);
    dwell(4'b1011, S3, 1'b0, 1'b0, 4'd0, 4'd0);
    an   = 4'b1101;
    sseg = SB;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_num1", {28'd0, num1}, 32'd0);
    chk("midrst_num2", {28'd0, num2}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
`ifdef SSEG2BCD_ERRCNT_EN
    chk("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    exp_cnt = 0;
    @(posedge clk); #1;
    an   = 4'b1111;
    sseg = SB;
    rst  = 1'b1;
    frame(SB, S3, SB, S9, 1'b0, 1'b1, 4'd3, 4'd9);
    chk("post_rst_err", {31'd0, err}, 32'd0);

    // Out-of-order capture: units2, tens1, tens2, units1 -> 12 and 7
    dwell(4'b1110, S7, 1'b0, 1'b0, 4'd0, 4'd0);
    dwell(4'b0111, S1, 1'b0, 1'b0, 4'd0, 4'd0);
    dwell(4'b1101, SB, 1'b0, 1'b0, 4'd0, 4'd0);
    dwell(4'b1011, S2, 1'b0, 1'b1, 4'd12, 4'd7);
    chk("order_err", {31'd0, err}, 32'd0);

    an   = 4'b1111;
    sseg = SB;
    repeat (10) @(posedge clk);
    #1;
    chk("pending_frames", exp_q.size(), 32'd0);
    chk("final_num1", {28'd0, num1}, 32'd12);
    chk("final_num2", {28'd0, num2}, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
